// File: rtl/riscv_pkg.sv
// riscv_pkg: constants shared by the fetch and decode stages of the 5-stage
// RISC-V pipeline.
//   XLEN          - data/address width
//   RESET_PC_DEF  - default first fetch address after reset
//   NOP_INSTR_DEF - bubble encoding (addi x0,x0,0)
//   opcode_e      - major opcodes (instr[6:0]) used by decode
package riscv_pkg;

   localparam int          XLEN          = 32;
   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b000_0011,
      OPC_OP_IMM = 7'b001_0011,
      OPC_AUIPC  = 7'b001_0111,
      OPC_STORE  = 7'b010_0011,
      OPC_OP     = 7'b011_0011,
      OPC_LUI    = 7'b011_0111,
      OPC_BRANCH = 7'b110_0011,
      OPC_JALR   = 7'b110_0111,
      OPC_JAL    = 7'b110_1111,
      OPC_SYSTEM = 7'b111_0011
   } opcode_e;

endpackage

// File: rtl/if_skid_buffer.sv
// if_skid_buffer: one-entry pc+instruction holding register. Catches a
// memory response that arrives while the downstream register is frozen.
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   load              - capture pc_in/instr_in and mark valid (wins over clear)
//   clear             - drop the held entry
//   pc_in, instr_in   - entry to capture
//   valid, pc, instr  - held entry
module if_skid_buffer #(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               clear,
   input  logic [PC_W-1:0]    pc_in,
   input  logic [INSTR_W-1:0] instr_in,
   output logic               valid,
   output logic [PC_W-1:0]    pc,
   output logic [INSTR_W-1:0] instr
);

   logic               valid_q, valid_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;

   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      if (load) begin
         valid_d = 1'b1;
         pc_d    = pc_in;
         instr_d = instr_in;
      end else if (clear) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         instr_q <= '0;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign valid = valid_q;
   assign pc    = pc_q;
   assign instr = instr_q;

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch. Owns the PC, issues one word fetch per cycle
// to a 1-cycle-latency instruction memory, and fills the IF/ID register.
// Stalls are absorbed by a one-entry skid buffer; EX redirects cost one
// bubble.
//   clk, reset           - rising-edge clock, synchronous active-high reset
//   stall                - hold IF/ID this cycle
//   redirect/redirect_pc - taken branch/jump target from EX (bits [1:0] ignored)
//   imem_req/imem_addr   - fetch request this cycle (word aligned)
//   imem_rdata           - word for the request issued last cycle
//   id_valid/id_pc/id_pc_plus4/id_instr - IF/ID register
module if_stage
   import riscv_pkg::*;
#(
   parameter int               XLEN      = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0]  RESET_PC  = RESET_PC_DEF[XLEN-1:0],
   parameter logic [31:0]      NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   output logic            id_valid,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_pc_plus4,
   output logic [31:0]     id_instr
);

   localparam logic [XLEN-1:0] FOUR = XLEN'(4);

   // Fetch state: implicit FSM on {req_valid_q, skid_valid}:
   // IDLE=00, FLOW=10, HELD=01.
   logic [XLEN-1:0] pc_q, pc_d;
   logic            req_valid_q, req_valid_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;

   // IF/ID register
   logic            id_valid_q, id_valid_d;
   logic [XLEN-1:0] id_pc_q, id_pc_d;
   logic [31:0]     id_instr_q, id_instr_d;

   logic            skid_load, skid_clear, skid_valid;
   logic [XLEN-1:0] skid_pc;
   logic [31:0]     skid_instr;
   logic [XLEN-1:0] target;

   // Masking instead of slicing keeps every redirect_pc bit in use.
   assign target = redirect_pc & ~XLEN'(3);

   if_skid_buffer #(.PC_W(XLEN), .INSTR_W(32)) u_skid (
      .clk      (clk),
      .reset    (reset),
      .load     (skid_load),
      .clear    (skid_clear),
      .pc_in    (req_pc_q),
      .instr_in (imem_rdata),
      .valid    (skid_valid),
      .pc       (skid_pc),
      .instr    (skid_instr)
   );

   always_comb begin
      pc_d        = pc_q;
      req_valid_d = req_valid_q;
      req_pc_d    = req_pc_q;
      id_valid_d  = id_valid_q;
      id_pc_d     = id_pc_q;
      id_instr_d  = id_instr_q;
      skid_load   = 1'b0;
      skid_clear  = 1'b0;
      imem_req    = 1'b0;
      imem_addr   = pc_q;

      if (reset) begin
         imem_addr   = RESET_PC;
         pc_d        = RESET_PC;
         req_valid_d = 1'b0;
         skid_clear  = 1'b1;
         id_valid_d  = 1'b0;
         id_pc_d     = '0;
         id_instr_d  = NOP_INSTR;
      end else if (redirect) begin
         // Fetch the target right now; whatever is in flight or held is
         // on the wrong path, so the slot becomes a bubble.
         imem_req    = 1'b1;
         imem_addr   = target;
         pc_d        = target + FOUR;
         req_valid_d = 1'b1;
         req_pc_d    = target;
         skid_clear  = 1'b1;
         id_valid_d  = 1'b0;
         id_instr_d  = NOP_INSTR;
      end else if (stall) begin
         // No new request; the word arriving now is parked in the skid.
         req_valid_d = 1'b0;
         skid_load   = req_valid_q;
      end else begin
         imem_req    = 1'b1;
         pc_d        = pc_q + FOUR;
         req_valid_d = 1'b1;
         req_pc_d    = pc_q;
         skid_clear  = 1'b1;
         if (skid_valid) begin
            id_valid_d = 1'b1;
            id_pc_d    = skid_pc;
            id_instr_d = skid_instr;
         end else if (req_valid_q) begin
            id_valid_d = 1'b1;
            id_pc_d    = req_pc_q;
            id_instr_d = imem_rdata;
         end else begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= RESET_PC;
         req_valid_q <= 1'b0;
         req_pc_q    <= '0;
         id_valid_q  <= 1'b0;
         id_pc_q     <= '0;
         id_instr_q  <= NOP_INSTR;
      end else begin
         pc_q        <= pc_d;
         req_valid_q <= req_valid_d;
         req_pc_q    <= req_pc_d;
         id_valid_q  <= id_valid_d;
         id_pc_q     <= id_pc_d;
         id_instr_q  <= id_instr_d;
      end
   end

   // A stall empties the request slot before filling the skid, and any
   // new request clears the skid, so both can never be live at once.
   a_no_req_and_skid: assert property (@(posedge clk) disable iff (reset)
      !(req_valid_q && skid_valid));

   assign id_valid    = id_valid_q;
   assign id_pc       = id_pc_q;
   assign id_pc_plus4 = id_pc_q + FOUR;
   assign id_instr    = id_instr_q;

endmodule
